// File: rtl/mem_bus_if.sv
// Memory-bus arbiter interface: requester handshakes, DMA bus request/grant and the
// external memory port. The arbiter uses the slave modport; requesters/bench the master.
interface mem_bus_if #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic                 ic_req;
    logic [WORD_SIZE-1:0] ic_addr;
    logic                 dc_req;
    logic                 dc_we;
    logic [WORD_SIZE-1:0] dc_addr;
    logic                 dma_br;
    logic                 bg;
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [IDX_W-1:0]     word_idx;
    logic                 ic_ack;
    logic                 dc_ack;
    logic                 ic_done;
    logic                 dc_done;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dma_br,
        output bg, mem_read, mem_write, mem_addr, word_idx,
               ic_ack, dc_ack, ic_done, dc_done
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dma_br,
        input  bg, mem_read, mem_write, mem_addr, word_idx,
               ic_ack, dc_ack, ic_done, dc_done
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between I-cache fills, D-cache
// fills/writebacks and a DMA controller. CPU owners get fixed-length line bursts with
// MEM_LATENCY cycles per word; DMA gets the whole bus via bg at a burst boundary.
// Optional macro ARB_ROUND_ROBIN_EN: alternate I/D priority on contested requests
// (loser of the last contest wins the next; pointer resets favouring D).
module mem_bus_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        Reset_N,
    mem_bus_if.slave    bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0]     LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [WORD_SIZE-1:0] LINE_MASK = ~WORD_SIZE'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, GRANT, RELEASE} state_t;

    state_t               state, state_nxt;
    logic                 owner_d;
    logic                 we;
    logic [WORD_SIZE-1:0] base;
    logic [LAT_W-1:0]     lat_cnt;
    logic [IDX_W-1:0]     word_idx;
    logic                 contest;
    logic                 pick_d;
    logic                 start;
    logic                 word_end;
    logic                 last_word;

    assign contest = bus.ic_req & bus.dc_req;
    assign start   = (state == IDLE) & ~bus.dma_br & (bus.ic_req | bus.dc_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic favor_i;

    // Priority pointer: after a contested I/D pick, favour whichever cache lost.
    always_ff @(posedge clk) begin
        if (!Reset_N)
            favor_i <= 1'b0;
        else if (start && contest)
            favor_i <= pick_d;
    end

    assign pick_d = bus.dc_req & ~(contest & favor_i);
`else
    assign pick_d = bus.dc_req;
`endif

    assign word_end  = (state == XFER) && (lat_cnt == '0);
    assign last_word = word_end && (word_idx == LAST_IDX);

    // State register; reset aborts any burst or grant at this edge.
    always_ff @(posedge clk) begin
        if (!Reset_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Burst context: owner/base/direction latched at the start, word timing counted down.
    always_ff @(posedge clk) begin
        if (!Reset_N) begin
            word_idx <= '0;
        end else if (start) begin
            owner_d  <= pick_d;
            we       <= pick_d & bus.dc_we;
            base     <= (pick_d ? bus.dc_addr : bus.ic_addr) & LINE_MASK;
            lat_cnt  <= LAT_LOAD;
            word_idx <= '0;
        end else if (state == XFER) begin
            if (lat_cnt == '0) begin
                lat_cnt  <= LAT_LOAD;
                word_idx <= word_idx + 1'b1;
            end else begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    // Next-state and output decode; everything idles low unless a state drives it.
    always_comb begin
        state_nxt     = state;
        bus.bg        = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.ic_ack    = 1'b0;
        bus.dc_ack    = 1'b0;
        bus.ic_done   = 1'b0;
        bus.dc_done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dma_br)
                    state_nxt = GRANT;
                else if (bus.ic_req || bus.dc_req)
                    state_nxt = XFER;
            end
            XFER: begin
                bus.mem_read  = ~we;
                bus.mem_write = we;
                bus.mem_addr  = base | WORD_SIZE'(word_idx);
                bus.ic_ack    = word_end & ~owner_d;
                bus.dc_ack    = word_end & owner_d;
                bus.ic_done   = last_word & ~owner_d;
                bus.dc_done   = last_word & owner_d;
                if (last_word)
                    state_nxt = IDLE;
            end
            GRANT: begin
                bus.bg = 1'b1;
                if (!bus.dma_br)
                    state_nxt = RELEASE;
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.word_idx = word_idx;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level reference model kept in this file.
module tb_mem_bus_arbiter;
    localparam int WS    = 16;
    localparam int LW    = 4;
    localparam int LAT   = 2;
    localparam int IDX_W = $clog2(LW);
    localparam int VW    = WS + IDX_W + 7;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic Reset_N;
    always #5 clk = ~clk;

    mem_bus_if #(.WORD_SIZE(WS), .LINE_WORDS(LW)) bus();

    mem_bus_arbiter #(.WORD_SIZE(WS), .LINE_WORDS(LW), .MEM_LATENCY(LAT)) dut (
        .clk     (clk),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 burst, 2 DMA owns bus, 3 dead cycle after DMA.
    int          m_mode;
    int          m_t;
    bit          m_owner_d;
    bit          m_we;
    bit          m_favor_i;
    logic [WS-1:0] m_base;
    logic [VW-1:0] e_vec;
    bit          e_icd, e_dcd;

    task automatic model_update();
        bit pick_d;
        if (!Reset_N) begin
            m_mode = 0; m_t = 0; m_favor_i = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (bus.dma_br) begin
                        m_mode = 2;
                    end else if (bus.ic_req || bus.dc_req) begin
                        pick_d = bus.dc_req && !(bus.ic_req && RR && m_favor_i);
                        if (bus.ic_req && bus.dc_req) m_favor_i = pick_d;
                        m_owner_d = pick_d;
                        m_we      = pick_d && bus.dc_we;
                        m_base    = (pick_d ? bus.dc_addr : bus.ic_addr) / LW * LW;
                        m_t       = 0;
                        m_mode    = 1;
                    end
                end
                1: begin
                    if (m_t == LW * LAT - 1) m_mode = 0;
                    else m_t = m_t + 1;
                end
                2: if (!bus.dma_br) m_mode = 3;
                default: m_mode = 0;
            endcase
        end
        begin
            int  word;
            bit  ack, done;
            logic [WS-1:0]    addr;
            logic [IDX_W-1:0] idx;
            word = m_t / LAT;
            ack  = (m_mode == 1) && (m_t % LAT == LAT - 1);
            done = ack && (word == LW - 1);
            addr = (m_mode == 1) ? m_base + WS'(word) : '0;
            idx  = (m_mode == 1) ? IDX_W'(word) : '0;
            e_icd = done && !m_owner_d;
            e_dcd = done && m_owner_d;
            e_vec = {m_mode == 2, m_mode == 1 && !m_we, m_mode == 1 && m_we, addr, idx,
                     ack && !m_owner_d, ack && m_owner_d, e_icd, e_dcd};
        end
    endtask

    task automatic check(input string tag);
        logic [VW-1:0] obs;
        obs = {bus.bg, bus.mem_read, bus.mem_write, bus.mem_addr, bus.word_idx,
               bus.ic_ack, bus.dc_ack, bus.ic_done, bus.dc_done};
        checks++;
        assert (obs === e_vec) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (bg,rd,wr,addr,idx,ica,dca,icd,dcd)",
                   tag, obs, e_vec);
        end
    endtask

    // One clock: model and DUT see the same inputs at the edge, outputs checked #1 later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check(tag);
    endtask

    // Requesters drop their request right after the model's done pulse.
    task automatic tick_drop(input string tag);
        tick(tag);
        if (e_icd) bus.ic_req = 1'b0;
        if (e_dcd) bus.dc_req = 1'b0;
    endtask

    task automatic serve(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick_drop(tag);
            n++;
        end while ((bus.ic_req || bus.dc_req || m_mode != 0) && n < budget);
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL %s_timeout: cycles %0d required below %0d", tag, n, budget);
        end
    endtask

    task automatic run_to_word(input string tag, input int w);
        for (int i = 0; i < 40 && !(m_mode == 1 && m_t / LAT == w); i++) tick_drop(tag);
    endtask

    initial begin
        Reset_N = 1'b0;
        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0;
        bus.dma_br = 1'b0;
        m_mode = 0; m_t = 0; m_owner_d = 1'b0; m_we = 1'b0; m_favor_i = 1'b0; m_base = '0;
        tick("reset");
        tick("reset");
        Reset_N = 1'b1;
        tick("idle");

        // I-cache fill at 0x0123
        bus.ic_req = 1'b1; bus.ic_addr = 16'h0123;
        serve("ic_fill", 30);
        tick("idle_after_ic");

        // D-cache writeback at 0x00F2
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 16'h00F2;
        serve("dc_wb", 30);

        // Simultaneous I and D, twice (second pair reorders under round robin)
        bus.dc_we = 1'b0; bus.dc_addr = 16'h0444; bus.ic_addr = 16'h0888;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1;
        serve("contest1", 60);
        bus.dc_addr = 16'h1235; bus.ic_addr = 16'h5679;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1;
        serve("contest2", 60);

        // DMA request at word 1 of an I burst; D request held off during grant
        bus.ic_req = 1'b1; bus.ic_addr = 16'hABCD;
        run_to_word("dma_mid", 1);
        bus.dma_br = 1'b1;
        bus.dc_req = 1'b1; bus.dc_addr = 16'h0F0F; bus.dc_we = 1'b1;
        for (int i = 0; i < 14; i++) tick_drop("dma_grant");
        bus.dma_br = 1'b0;
        serve("dma_release", 40);

        // Reset mid-burst at word 2, then the held request restarts cleanly
        bus.ic_req = 1'b1; bus.ic_addr = 16'h7777;
        run_to_word("pre_abort", 2);
        Reset_N = 1'b0;
        tick("abort_reset");
        Reset_N = 1'b1;
        serve("after_abort", 30);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!bus.ic_req && $urandom_range(3) == 0) begin
                bus.ic_req = 1'b1; bus.ic_addr = WS'($urandom);
            end
            if (!bus.dc_req && $urandom_range(3) == 0) begin
                bus.dc_req = 1'b1; bus.dc_addr = WS'($urandom); bus.dc_we = 1'($urandom);
            end
            if (bus.dma_br) begin
                if ($urandom_range(7) == 0) bus.dma_br = 1'b0;
            end else if ($urandom_range(15) == 0) begin
                bus.dma_br = 1'b1;
            end
            Reset_N = ($urandom_range(199) != 0);
            tick_drop("random");
        end
        Reset_N = 1'b1;
        bus.dma_br = 1'b0;
        serve("drain", 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
